// File: rtl/calc_pkg.sv
// Shared definitions for the RPN calculator sequencer: numpad key indices,
// sequencer state encoding and the digit lookup.
package calc_pkg;

  localparam logic [3:0] KEY_0    = 4'b0011;
  localparam logic [3:0] KEY_1    = 4'b0000;
  localparam logic [3:0] KEY_2    = 4'b0100;
  localparam logic [3:0] KEY_3    = 4'b1000;
  localparam logic [3:0] KEY_4    = 4'b0001;
  localparam logic [3:0] KEY_5    = 4'b0101;
  localparam logic [3:0] KEY_6    = 4'b1001;
  localparam logic [3:0] KEY_7    = 4'b0010;
  localparam logic [3:0] KEY_8    = 4'b0110;
  localparam logic [3:0] KEY_9    = 4'b1010;
  localparam logic [3:0] KEY_PUSH = 4'b1100;
  localparam logic [3:0] KEY_ADD  = 4'b1101;
  localparam logic [3:0] KEY_SUB  = 4'b1110;
  localparam logic [3:0] KEY_MUL  = 4'b1111;
  localparam logic [3:0] KEY_DIV  = 4'b1011;
  localparam logic [3:0] KEY_NEG  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV     = 2'd1,
    EXEC    = 2'd2,
    RELEASE = 2'd3
  } seq_state_t;

  function automatic logic [3:0] digit_value(input logic [3:0] key);
    logic [3:0] d;
    case (key)
      KEY_0:   d = 4'd0;
      KEY_1:   d = 4'd1;
      KEY_2:   d = 4'd2;
      KEY_3:   d = 4'd3;
      KEY_4:   d = 4'd4;
      KEY_5:   d = 4'd5;
      KEY_6:   d = 4'd6;
      KEY_7:   d = 4'd7;
      KEY_8:   d = 4'd8;
      KEY_9:   d = 4'd9;
      default: d = 4'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/calc_serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The start cycle
// already resolves the first bit, so done pulses WIDTH cycles after start.
module calc_serial_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_src, quo_src, dvs_src, rem_n, quo_n;
  logic [WIDTH:0]   rem_sh, diff;
  logic             fits;

  always_comb begin
    rem_src = start ? '0       : rem_q;
    quo_src = start ? dividend : quo_q;
    dvs_src = start ? divisor  : dvs_q;
    rem_sh  = {rem_src, quo_src[WIDTH-1]};
    diff    = rem_sh - {1'b0, dvs_src};
    fits    = ~diff[WIDTH];
    rem_n   = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_n   = {quo_src[WIDTH-2:0], fits};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        dvs_q <= divisor;
        cnt_q <= CW'(WIDTH - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/calc_op_sequencer.sv
// Turns numpad presses into single push/pop/write stack transactions.
// States: IDLE wait press | DIV serial divide | EXEC strobe cycle | RELEASE wait key up
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6,
  parameter int DEPTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       key_code,
  input  logic [WIDTH-1:0] top,
  input  logic [WIDTH-1:0] next,
  input  logic [CNT_W-1:0] count,
  output logic             push,
  output logic             pop,
  output logic             write,
  output logic [WIDTH-1:0] new_value,
  output logic             busy,
  output logic             op_error
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

  seq_state_t       state_q, state_d;
  logic             key_prev_q, armed_q, press, accept, div_start;
  logic [3:0]       key_q;
  logic [WIDTH-1:0] top_q, next_q;
  logic [CNT_W-1:0] count_q;
  logic             push_q, pop_q, write_q;

  logic [3:0]       src_key;
  logic [WIDTH-1:0] src_top, src_next, div_result;
  logic [CNT_W-1:0] src_count;
  logic             r_push, r_pop, r_write, r_err;
  logic [WIDTH-1:0] r_value;

  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_quotient, abs_top, abs_next;

  // armed blocks a key that was already down when reset released
  assign press = key_code[4] & ~key_prev_q & armed_q;

  // Decisions at acceptance use live operands; at divide completion the latched ones.
  assign src_key   = (state_q == IDLE) ? key_code[3:0] : key_q;
  assign src_top   = (state_q == IDLE) ? top           : top_q;
  assign src_next  = (state_q == IDLE) ? next          : next_q;
  assign src_count = (state_q == IDLE) ? count         : count_q;

  assign abs_top    = top[WIDTH-1]  ? -top  : top;
  assign abs_next   = next[WIDTH-1] ? -next : next;
  assign div_result = (next_q[WIDTH-1] ^ top_q[WIDTH-1]) ? -div_quotient : div_quotient;

  calc_serial_divider #(.WIDTH(WIDTH)) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .dividend (abs_next),
    .divisor  (abs_top),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_comb begin
    r_push  = 1'b0;
    r_pop   = 1'b0;
    r_write = 1'b0;
    r_err   = 1'b0;
    r_value = '0;
    case (src_key)
      KEY_PUSH: begin
        if (src_count < DEPTH_C) r_push = 1'b1;
        else                     r_err  = 1'b1;
      end
      KEY_ADD, KEY_SUB, KEY_MUL: begin
        if (src_count >= TWO_C) begin
          r_pop   = 1'b1;
          r_write = 1'b1;
          if (src_key == KEY_ADD)      r_value = src_next + src_top;
          else if (src_key == KEY_SUB) r_value = src_next - src_top;
          else                         r_value = src_next * src_top;
        end else begin
          r_err = 1'b1;
        end
      end
      KEY_DIV: begin
        if (src_count < TWO_C || src_top == '0) begin
          r_err = 1'b1;
        end else begin
          r_pop   = 1'b1;
          r_write = 1'b1;
          r_value = div_result;
        end
      end
      KEY_NEG: begin
        r_write = 1'b1;
        r_value = -src_top;
      end
      default: begin
        r_write = 1'b1;
        r_value = src_top * WIDTH'(10) + WIDTH'(digit_value(src_key));
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          accept = 1'b1;
          if (key_code[3:0] != KEY_DIV) begin
            state_d = EXEC;
          end else if (r_err) begin
            state_d = RELEASE;
          end else begin
            state_d   = DIV;
            div_start = 1'b1;
          end
        end
      end
      DIV: begin
        if (div_done)      state_d = EXEC;
        else if (!div_busy) state_d = RELEASE;
      end
      EXEC:    state_d = RELEASE;
      RELEASE: if (!key_code[4]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      key_prev_q <= 1'b0;
      armed_q    <= ~key_code[4];
      key_q      <= '0;
      top_q      <= '0;
      next_q     <= '0;
      count_q    <= '0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      write_q    <= 1'b0;
      new_value  <= '0;
      op_error   <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= key_code[4];
      if (!key_code[4]) armed_q <= 1'b1;
      if (accept) begin
        key_q    <= key_code[3:0];
        top_q    <= top;
        next_q   <= next;
        count_q  <= count;
        op_error <= r_err;
      end
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      write_q <= 1'b0;
      if (state_d == EXEC) begin
        push_q  <= r_push;
        pop_q   <= r_pop;
        write_q <= r_write;
        if (r_write) new_value <= r_value;
      end
    end
  end

  // Gated so an op aborted by reset never shows a strobe, even in the reset cycle.
  assign push  = push_q  & ~reset;
  assign pop   = pop_q   & ~reset;
  assign write = write_q & ~reset;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: directed scenarios plus randomized ops checked
// against an arithmetic model of the calculator rules.
module tb_calc_op_sequencer;

  localparam logic [3:0] K_PUSH = 4'b1100, K_ADD = 4'b1101, K_SUB = 4'b1110;
  localparam logic [3:0] K_MUL  = 4'b1111, K_DIV = 4'b1011, K_NEG = 4'b0111;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  key_code;
  logic [31:0] top, next;
  logic [5:0]  count;
  logic        push, pop, write, busy, op_error;
  logic [31:0] new_value;

  int total  = 0;
  int passed = 0;

  typedef struct {
    bit          push, pop, write, err;
    logic [31:0] val;
    int          lat;
  } exp_t;

  typedef struct {
    int          nstrobe, lat, busy_cycles;
    bit          push, pop, write, err;
    logic [31:0] val;
  } obs_t;

  calc_op_sequencer #(.WIDTH(32), .CNT_W(6), .DEPTH(32)) dut (
    .clock(clock), .reset(reset), .key_code(key_code), .top(top), .next(next),
    .count(count), .push(push), .pop(pop), .write(write), .new_value(new_value),
    .busy(busy), .op_error(op_error)
  );

  always #10 clock = ~clock;

  function automatic exp_t model(input logic [3:0] k, input logic [31:0] t, input logic [31:0] n,
                                 input logic [5:0] c);
    exp_t   e;
    longint st, sn, q;
    int     d;
    e = '{default: 0};
    e.lat = 1;
    st = longint'($signed(t));
    sn = longint'($signed(n));
    d = -1;
    case (k)
      4'b0011: d = 0;
      4'b0000: d = 1;
      4'b0100: d = 2;
      4'b1000: d = 3;
      4'b0001: d = 4;
      4'b0101: d = 5;
      4'b1001: d = 6;
      4'b0010: d = 7;
      4'b0110: d = 8;
      4'b1010: d = 9;
      K_PUSH: if (c < 32) e.push = 1; else e.err = 1;
      K_ADD, K_SUB, K_MUL: begin
        if (c >= 2) begin
          e.pop = 1; e.write = 1;
          if (k == K_ADD)      e.val = n + t;
          else if (k == K_SUB) e.val = n - t;
          else                 e.val = 32'(sn * st);
        end else e.err = 1;
      end
      K_DIV: begin
        if (c < 2 || t == 0) e.err = 1;
        else begin
          q = sn / st;
          e.pop = 1; e.write = 1; e.val = q[31:0]; e.lat = 33;
        end
      end
      default: begin e.write = 1; e.val = -t; end
    endcase
    if (d >= 0) begin
      e.write = 1;
      e.val = t * 32'd10 + 32'(d);
    end
    return e;
  endfunction

  // Presses key k for `hold` cycles; optionally releases and re-presses ADD mid-op.
  task automatic press_op(input logic [3:0] k, input logic [31:0] t, input logic [31:0] n,
                          input logic [5:0] c, input int hold, input int glitch, output obs_t o);
    int window;
    o = '{default: 0};
    o.lat = -1;
    window = ((hold > 40) ? hold : 40) + 4;
    @(posedge clock); #1;
    key_code = {1'b1, k}; top = t; next = n; count = c;
    for (int i = 0; i < window; i++) begin
      @(negedge clock);
      if (push | pop | write) begin
        if (o.nstrobe == 0) begin
          o.lat = i; o.push = push; o.pop = pop; o.write = write; o.val = new_value;
        end
        o.nstrobe++;
      end
      if (busy) o.busy_cycles++;
      @(posedge clock); #1;
      if (i == 0) begin top = $urandom; next = $urandom; count = 6'($urandom); end
      if (glitch >= 0 && i == glitch) key_code[4] = 1'b0;
      if (glitch >= 0 && i == glitch + 1) key_code = {1'b1, K_ADD};
      if (i + 1 == hold) key_code[4] = 1'b0;
    end
    o.err = op_error;
  endtask

  task automatic test_reset();
    reset = 1'b1; key_code = '0; top = '0; next = '0; count = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++;
    if ({push, pop, write, busy, op_error} !== 5'b0)
      $display("FAIL reset_ctrl got %b exp 00000", {push, pop, write, busy, op_error});
    else passed++;
    total++;
    if (new_value !== 32'd0) $display("FAIL reset_value got %h exp 0", new_value);
    else passed++;
    @(posedge clock); #1; reset = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_digit_hold();
    obs_t o;
    press_op(4'b0101, 32'd12, 32'd0, 6'd3, 20, -1, o);
    total++;
    if (o.nstrobe !== 1) $display("FAIL hold_strobes got %0d exp 1", o.nstrobe); else passed++;
    total++;
    if ({o.push, o.pop, o.write} !== 3'b001) $display("FAIL hold_ppw got %b exp 001", {o.push, o.pop, o.write});
    else passed++;
    total++;
    if (o.val !== 32'd125) $display("FAIL hold_value got %0d exp 125", o.val); else passed++;
    total++;
    if (o.lat !== 1) $display("FAIL hold_latency got %0d exp 1", o.lat); else passed++;
    total++;
    if (o.busy_cycles !== 20) $display("FAIL hold_busy got %0d exp 20", o.busy_cycles); else passed++;
  endtask

  task automatic test_sub();
    obs_t o;
    press_op(K_SUB, -32'sd3, 32'd7, 6'd2, 3, -1, o);
    total++;
    if ({o.push, o.pop, o.write} !== 3'b011 || o.lat !== 1)
      $display("FAIL sub_ppw got %b lat %0d exp 011 lat 1", {o.push, o.pop, o.write}, o.lat);
    else passed++;
    total++;
    if (o.val !== 32'd10 || o.nstrobe !== 1)
      $display("FAIL sub_value got %0d n=%0d exp 10 n=1", o.val, o.nstrobe);
    else passed++;
    total++;
    if (o.busy_cycles !== 3) $display("FAIL sub_busy got %0d exp 3", o.busy_cycles); else passed++;
  endtask

  task automatic test_div();
    obs_t o;
    press_op(K_DIV, 32'd2, -32'sd7, 6'd4, 2, -1, o);
    total++;
    if (o.lat !== 33) $display("FAIL div_latency got %0d exp 33", o.lat); else passed++;
    total++;
    if (o.val !== 32'hFFFF_FFFD || {o.pop, o.write} !== 2'b11 || o.nstrobe !== 1)
      $display("FAIL div_value got %h pw %b n=%0d exp fffffffd 11 1", o.val, {o.pop, o.write}, o.nstrobe);
    else passed++;
    total++;
    if (o.busy_cycles !== 34) $display("FAIL div_busy got %0d exp 34", o.busy_cycles); else passed++;
    press_op(K_DIV, 32'hFFFF_FFFF, 32'h8000_0000, 6'd2, 2, -1, o);
    total++;
    if (o.val !== 32'h8000_0000 || o.nstrobe !== 1)
      $display("FAIL div_wrap got %h n=%0d exp 80000000 1", o.val, o.nstrobe);
    else passed++;
  endtask

  task automatic test_errors();
    obs_t o;
    press_op(K_DIV, 32'd0, 32'd9, 6'd5, 2, -1, o);
    total++;
    if (o.nstrobe !== 0 || o.err !== 1'b1 || o.busy_cycles !== 2)
      $display("FAIL div0 got n=%0d err %b busy %0d exp 0 1 2", o.nstrobe, o.err, o.busy_cycles);
    else passed++;
    press_op(4'b0000, 32'd4, 32'd0, 6'd1, 1, -1, o);
    total++;
    if (o.err !== 1'b0 || o.val !== 32'd41)
      $display("FAIL err_clear got err %b val %0d exp 0 41", o.err, o.val);
    else passed++;
    press_op(K_ADD, 32'd4, 32'd5, 6'd1, 2, -1, o);
    total++;
    if (o.nstrobe !== 0 || o.err !== 1'b1)
      $display("FAIL add_underflow got n=%0d err %b exp 0 1", o.nstrobe, o.err);
    else passed++;
    press_op(K_NEG, 32'd5, 32'd0, 6'd1, 2, -1, o);
    total++;
    if (o.err !== 1'b0 || o.val !== 32'hFFFF_FFFB)
      $display("FAIL neg_clear got err %b val %h exp 0 fffffffb", o.err, o.val);
    else passed++;
    press_op(K_DIV, 32'd3, 32'd9, 6'd1, 2, -1, o);
    total++;
    if (o.nstrobe !== 0 || o.err !== 1'b1)
      $display("FAIL div_underflow got n=%0d err %b exp 0 1", o.nstrobe, o.err);
    else passed++;
  endtask

  task automatic test_push_boundary();
    obs_t o;
    press_op(K_PUSH, 32'd1, 32'd2, 6'd32, 2, -1, o);
    total++;
    if (o.nstrobe !== 0 || o.err !== 1'b1)
      $display("FAIL push_full got n=%0d err %b exp 0 1", o.nstrobe, o.err);
    else passed++;
    press_op(K_PUSH, 32'd1, 32'd2, 6'd31, 2, -1, o);
    total++;
    if (o.nstrobe !== 1 || {o.push, o.pop, o.write} !== 3'b100 || o.err !== 1'b0)
      $display("FAIL push_ok got n=%0d ppw %b err %b exp 1 100 0", o.nstrobe, {o.push, o.pop, o.write}, o.err);
    else passed++;
  endtask

  task automatic test_back_to_back();
    obs_t o;
    press_op(K_DIV, 32'd7, 32'd100, 6'd2, 10, 3, o);
    total++;
    if (o.nstrobe !== 1 || o.val !== 32'd14 || o.lat !== 33)
      $display("FAIL busy_ignore got n=%0d val %0d lat %0d exp 1 14 33", o.nstrobe, o.val, o.lat);
    else passed++;
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    logic [3:0]  k;
    logic [31:0] t, n;
    logic [5:0]  c;
    for (int it = 0; it < 40; it++) begin
      k = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       t = $urandom;
        1:       t = 32'($urandom_range(0, 200)) - 32'd100;
        2:       t = 32'd0;
        default: t = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      endcase
      case ($urandom_range(0, 2))
        0:       n = $urandom;
        1:       n = 32'($urandom_range(0, 2000)) - 32'd1000;
        default: n = 32'h8000_0000;
      endcase
      case ($urandom_range(0, 5))
        0: c = 6'd0;
        1: c = 6'd1;
        2: c = 6'd2;
        3: c = 6'd31;
        4: c = 6'd32;
        default: c = 6'($urandom_range(0, 40));
      endcase
      e = model(k, t, n, c);
      press_op(k, t, n, c, int'($urandom_range(1, 5)), -1, o);
      total++;
      if (o.nstrobe !== ((e.push | e.pop | e.write) ? 1 : 0) ||
          {o.push, o.pop, o.write} !== {e.push, e.pop, e.write})
        $display("FAIL rnd_strobe k=%b n=%0d ppw %b exp ppw %b", k, o.nstrobe,
                 {o.push, o.pop, o.write}, {e.push, e.pop, e.write});
      else passed++;
      if (e.write) begin
        total++;
        if (o.val !== e.val || o.lat !== e.lat)
          $display("FAIL rnd_value k=%b got %h lat %0d exp %h lat %0d", k, o.val, o.lat, e.val, e.lat);
        else passed++;
      end
      total++;
      if (o.err !== e.err) $display("FAIL rnd_error k=%b got %b exp %b", k, o.err, e.err);
      else passed++;
    end
  endtask

  task automatic test_abort();
    obs_t o;
    int   seen, busy_seen;
    seen = 0;
    @(posedge clock); #1;
    key_code = {1'b1, K_DIV}; top = 32'd3; next = 32'd50; count = 6'd2;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (push | pop | write) seen++;
      @(posedge clock); #1;
      if (i == 9)  reset = 1'b1;
      if (i == 11) reset = 1'b0;
      if (i == 20) key_code[4] = 1'b0;
    end
    total++;
    if (seen !== 0 || busy !== 1'b0) $display("FAIL abort_div got strobes %0d busy %b exp 0 0", seen, busy);
    else passed++;

    seen = 0;
    @(posedge clock); #1;
    key_code = {1'b1, 4'b0000}; top = 32'd1; count = 6'd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (push | pop | write) seen++;
      @(posedge clock); #1;
      if (i == 0) reset = 1'b1;
      if (i == 1) begin reset = 1'b0; key_code[4] = 1'b0; end
    end
    total++;
    if (seen !== 0) $display("FAIL abort_exec got strobes %0d exp 0", seen); else passed++;

    seen = 0; busy_seen = 0;
    @(posedge clock); #1;
    reset = 1'b1; key_code = {1'b1, K_MUL}; top = 32'd6; next = 32'd7; count = 6'd3;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (push | pop | write) seen++;
      if (busy) busy_seen++;
    end
    total++;
    if (seen !== 0 || busy_seen !== 0)
      $display("FAIL held_through_reset got strobes %0d busy %0d exp 0 0", seen, busy_seen);
    else passed++;
    @(posedge clock); #1; key_code[4] = 1'b0;
    repeat (2) @(posedge clock);
    press_op(K_MUL, 32'd6, 32'd7, 6'd3, 2, -1, o);
    total++;
    if (o.nstrobe !== 1 || o.val !== 32'd42) $display("FAIL repress_mul got n=%0d val %0d exp 1 42", o.nstrobe, o.val);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_digit_hold();
    test_sub();
    test_div();
    test_errors();
    test_push_boundary();
    test_back_to_back();
    test_random();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
